// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one AXI-lite master request port between the
// instruction-fetch bus (read-only) and the load/store data bus.
// One request is latched at a time and held until the master completes.
// The response goes back to the requester that won the grant. At least one
// idle cycle always separates two transfers.
module mem_bus_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ibus_valid_i,
  output logic                  ibus_ready_o,
  input  logic [ADDR_WIDTH-1:0] ibus_addr_i,
  output logic [DATA_WIDTH-1:0] ibus_rdata_o,
  input  logic                  dbus_valid_i,
  output logic                  dbus_ready_o,
  input  logic [ADDR_WIDTH-1:0] dbus_addr_i,
  input  logic [DATA_WIDTH-1:0] dbus_wdata_i,
  input  logic [3:0]            dbus_we_i,
  output logic [DATA_WIDTH-1:0] dbus_rdata_o,
  output logic                  m_valid_o,
  input  logic                  m_ready_i,
  output logic [ADDR_WIDTH-1:0] m_addr_o,
  output logic [DATA_WIDTH-1:0] m_wdata_o,
  output logic [3:0]            m_we_o,
  input  logic [DATA_WIDTH-1:0] m_rdata_i
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t state;
  state_t state_next;

  // prio: 1 = dbus wins a tie, 0 = ibus wins a tie
  logic prio;
  // gnt: 1 = dbus owns the current transfer, 0 = ibus owns it
  logic gnt;
  // abandon: the owner dropped its valid while the transfer was in flight
  logic abandon;

  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [3:0]            we_q;

  logic grant_en;
  logic pick_dbus;
  logic complete;
  logic owner_valid;

  // The master sees only registered state, so requester inputs never reach it combinationally
  assign m_valid_o = (state == BUSY);
  assign m_addr_o  = addr_q;
  assign m_wdata_o = wdata_q;
  assign m_we_o    = we_q;

  assign owner_valid = gnt ? dbus_valid_i : ibus_valid_i;

  // State register; a reset in the middle of a transfer simply drops it
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Arbitration and next state, plus the combinational completion strobe back to the owner
  always_comb begin
    state_next   = state;
    grant_en     = 1'b0;
    pick_dbus    = 1'b0;
    complete     = 1'b0;
    ibus_ready_o = 1'b0;
    dbus_ready_o = 1'b0;
    ibus_rdata_o = '0;
    dbus_rdata_o = '0;
    case (state)
      IDLE: begin
        if (ibus_valid_i || dbus_valid_i) begin
          grant_en   = 1'b1;
          pick_dbus  = dbus_valid_i && (!ibus_valid_i || prio);
          state_next = BUSY;
        end
      end
      BUSY: begin
        if (m_ready_i) begin
          complete   = 1'b1;
          state_next = IDLE;
          if (!abandon) begin
            if (gnt) begin
              dbus_ready_o = 1'b1;
              dbus_rdata_o = m_rdata_i;
            end else begin
              ibus_ready_o = 1'b1;
              ibus_rdata_o = m_rdata_i;
            end
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Latch the winning request; a fetch never writes, so its enables and data are zeroed
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= '0;
      gnt     <= 1'b0;
      prio    <= 1'b1;
    end else if (grant_en) begin
      addr_q  <= pick_dbus ? dbus_addr_i  : ibus_addr_i;
      wdata_q <= pick_dbus ? dbus_wdata_i : '0;
      we_q    <= pick_dbus ? dbus_we_i    : 4'b0000;
      gnt     <= pick_dbus;
      prio    <= ~pick_dbus;
    end
  end

  // Sticky abandon: set when the owner lets go mid-transfer, cleared when the transfer retires
  always_ff @(posedge clk) begin
    if (rst) begin
      abandon <= 1'b0;
    end else if (state == IDLE) begin
      abandon <= 1'b0;
    end else if (complete) begin
      abandon <= 1'b0;
    end else if (!owner_valid) begin
      abandon <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: directed self-checking bench for mem_bus_arbiter.
// Expected grants are queued when a request is driven. They are popped and
// compared when the arbiter raises m_valid_o.
module tb_mem_bus_arbiter;

  logic        clk;
  logic        rst;
  logic        ibus_valid_i;
  logic        ibus_ready_o;
  logic [31:0] ibus_addr_i;
  logic [31:0] ibus_rdata_o;
  logic        dbus_valid_i;
  logic        dbus_ready_o;
  logic [31:0] dbus_addr_i;
  logic [31:0] dbus_wdata_i;
  logic [3:0]  dbus_we_i;
  logic [31:0] dbus_rdata_o;
  logic        m_valid_o;
  logic        m_ready_i;
  logic [31:0] m_addr_o;
  logic [31:0] m_wdata_o;
  logic [3:0]  m_we_o;
  logic [31:0] m_rdata_i;

  typedef struct {
    bit          is_dbus;
    bit          drop;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  we;
  } exp_t;

  exp_t sb[$];
  int   compared = 0;
  int   mismatched = 0;
  int   waited;

  localparam logic [31:0] JUNK = 32'hBAD0BAD0;

  mem_bus_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .ibus_valid_i (ibus_valid_i),
    .ibus_ready_o (ibus_ready_o),
    .ibus_addr_i  (ibus_addr_i),
    .ibus_rdata_o (ibus_rdata_o),
    .dbus_valid_i (dbus_valid_i),
    .dbus_ready_o (dbus_ready_o),
    .dbus_addr_i  (dbus_addr_i),
    .dbus_wdata_i (dbus_wdata_i),
    .dbus_we_i    (dbus_we_i),
    .dbus_rdata_o (dbus_rdata_o),
    .m_valid_o    (m_valid_o),
    .m_ready_i    (m_ready_i),
    .m_addr_o     (m_addr_o),
    .m_wdata_o    (m_wdata_o),
    .m_we_o       (m_we_o),
    .m_rdata_i    (m_rdata_i)
  );

  // Free-running clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case something never terminates
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed no finish, expected finish before 200000");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic pushExpect(input bit is_dbus, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [3:0] we, input bit drop);
    exp_t e;
    e.is_dbus = is_dbus;
    e.drop    = drop;
    e.addr    = addr;
    e.wdata   = is_dbus ? wdata : 32'h0;
    e.we      = is_dbus ? we : 4'h0;
    sb.push_back(e);
  endtask

  task automatic applyStimulus(input bit is_dbus, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [3:0] we, input bit drop);
    if (is_dbus) begin
      dbus_valid_i = 1'b1;
      dbus_addr_i  = addr;
      dbus_wdata_i = wdata;
      dbus_we_i    = we;
    end else begin
      ibus_valid_i = 1'b1;
      ibus_addr_i  = addr;
    end
    pushExpect(is_dbus, addr, wdata, we, drop);
  endtask

  // Acts as the AXI-lite master: wait for a request, respond after lat cycles, check the idle gap
  task automatic serve(input int lat, input logic [31:0] rdata, output int wait_cycles);
    exp_t e;
    wait_cycles = 0;
    do begin
      step();
      #1;
      wait_cycles++;
    end while (!m_valid_o && wait_cycles < 20);
    if (!m_valid_o) begin
      checkOutput("grant_timeout", {31'b0, m_valid_o}, 32'h1);
      return;
    end
    if (sb.size() == 0) begin
      checkOutput("sb_empty", 32'h0, 32'h1);
      return;
    end
    e = sb.pop_front();
    checkOutput("m_addr", m_addr_o, e.addr);
    checkOutput("m_wdata", m_wdata_o, e.wdata);
    checkOutput("m_we", {28'b0, m_we_o}, {28'b0, e.we});
    for (int i = 1; i < lat; i++) begin
      step();
      m_rdata_i = JUNK;
      if (i == 1 && e.drop) begin
        if (e.is_dbus) dbus_valid_i = 1'b0;
        else           ibus_valid_i = 1'b0;
      end
      #1;
      checkOutput("busy_valid", {31'b0, m_valid_o}, 32'h1);
      checkOutput("busy_addr", m_addr_o, e.addr);
      checkOutput("busy_we", {28'b0, m_we_o}, {28'b0, e.we});
      checkOutput("busy_ready", {30'b0, ibus_ready_o, dbus_ready_o}, 32'h0);
      checkOutput("busy_rdata", ibus_rdata_o | dbus_rdata_o, 32'h0);
    end
    step();
    m_ready_i = 1'b1;
    m_rdata_i = rdata;
    #1;
    checkOutput("ibus_ready", {31'b0, ibus_ready_o}, {31'b0, (!e.is_dbus && !e.drop)});
    checkOutput("dbus_ready", {31'b0, dbus_ready_o}, {31'b0, (e.is_dbus && !e.drop)});
    checkOutput("ibus_rdata", ibus_rdata_o, (!e.is_dbus && !e.drop) ? rdata : 32'h0);
    checkOutput("dbus_rdata", dbus_rdata_o, (e.is_dbus && !e.drop) ? rdata : 32'h0);
    step();
    m_ready_i = 1'b0;
    m_rdata_i = JUNK;
    #1;
    checkOutput("gap_valid", {31'b0, m_valid_o}, 32'h0);
    checkOutput("gap_ready", {30'b0, ibus_ready_o, dbus_ready_o}, 32'h0);
  endtask

  // Directed sequence
  initial begin
    rst          = 1'b1;
    ibus_valid_i = 1'b0;
    ibus_addr_i  = '0;
    dbus_valid_i = 1'b0;
    dbus_addr_i  = '0;
    dbus_wdata_i = '0;
    dbus_we_i    = '0;
    m_ready_i    = 1'b1;
    m_rdata_i    = JUNK;

    // Reset state
    step();
    step();
    #1;
    checkOutput("rst_valid", {31'b0, m_valid_o}, 32'h0);
    checkOutput("rst_addr", m_addr_o, 32'h0);
    checkOutput("rst_wdata", m_wdata_o, 32'h0);
    checkOutput("rst_we", {28'b0, m_we_o}, 32'h0);
    checkOutput("rst_ready", {30'b0, ibus_ready_o, dbus_ready_o}, 32'h0);
    checkOutput("rst_rdata", ibus_rdata_o | dbus_rdata_o, 32'h0);
    step();
    rst       = 1'b0;
    m_ready_i = 1'b0;

    // Spurious ready while idle
    step();
    m_ready_i = 1'b1;
    #1;
    checkOutput("spur_ready", {30'b0, ibus_ready_o, dbus_ready_o}, 32'h0);
    checkOutput("spur_rdata", ibus_rdata_o | dbus_rdata_o, 32'h0);
    step();
    m_ready_i = 1'b0;
    #1;
    checkOutput("spur_valid", {31'b0, m_valid_o}, 32'h0);

    // Single fetch; idle dbus carries junk store data that must not leak
    dbus_wdata_i = 32'h55555555;
    dbus_we_i    = 4'hF;
    applyStimulus(1'b0, 32'h100, 32'h0, 4'h0, 1'b0);
    serve(3, 32'hDEADBEEF, waited);
    checkOutput("fetch_latency", waited, 32'd1);
    ibus_valid_i = 1'b0;

    // Store
    step();
    applyStimulus(1'b1, 32'h2000, 32'h12345678, 4'hF, 1'b0);
    serve(3, 32'h0, waited);
    checkOutput("store_latency", waited, 32'd1);
    dbus_valid_i = 1'b0;

    // Contention after a fresh reset: dbus, ibus, dbus, ibus
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    applyStimulus(1'b1, 32'h3000, 32'hA5A5A5A5, 4'h3, 1'b0);
    applyStimulus(1'b0, 32'h200, 32'h0, 4'h0, 1'b0);
    pushExpect(1'b1, 32'h3000, 32'hA5A5A5A5, 4'h3, 1'b0);
    pushExpect(1'b0, 32'h200, 32'h0, 4'h0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      serve(2, 32'h1000 + k, waited);
      checkOutput("cont_gap", waited, 32'd1);
    end
    ibus_valid_i = 1'b0;
    dbus_valid_i = 1'b0;

    // Abandoned dbus load, then a normal fetch
    step();
    applyStimulus(1'b1, 32'h4000, 32'h0, 4'h0, 1'b1);
    serve(3, 32'hCAFEF00D, waited);
    dbus_valid_i = 1'b0;
    step();
    applyStimulus(1'b0, 32'h104, 32'h0, 4'h0, 1'b0);
    serve(2, 32'h0BADC0DE, waited);
    checkOutput("after_abandon_latency", waited, 32'd1);
    ibus_valid_i = 1'b0;

    // Reset in the middle of a dbus store, then both request
    step();
    dbus_valid_i = 1'b1;
    dbus_addr_i  = 32'h5000;
    dbus_wdata_i = 32'h87654321;
    dbus_we_i    = 4'hC;
    step();
    #1;
    checkOutput("pre_rst_valid", {31'b0, m_valid_o}, 32'h1);
    checkOutput("pre_rst_we", {28'b0, m_we_o}, 32'hC);
    step();
    rst          = 1'b1;
    ibus_valid_i = 1'b1;
    ibus_addr_i  = 32'h300;
    m_ready_i    = 1'b1;
    step();
    #1;
    checkOutput("midrst_valid", {31'b0, m_valid_o}, 32'h0);
    checkOutput("midrst_addr", m_addr_o, 32'h0);
    checkOutput("midrst_wdata", m_wdata_o, 32'h0);
    checkOutput("midrst_we", {28'b0, m_we_o}, 32'h0);
    checkOutput("midrst_ready", {30'b0, ibus_ready_o, dbus_ready_o}, 32'h0);
    checkOutput("midrst_rdata", ibus_rdata_o | dbus_rdata_o, 32'h0);
    rst       = 1'b0;
    m_ready_i = 1'b0;
    pushExpect(1'b1, 32'h5000, 32'h87654321, 4'hC, 1'b0);
    serve(2, 32'h77777777, waited);
    checkOutput("post_rst_latency", waited, 32'd1);
    ibus_valid_i = 1'b0;
    dbus_valid_i = 1'b0;

    step();
    step();
    #1;
    checkOutput("final_idle", {31'b0, m_valid_o}, 32'h0);
    checkOutput("sb_drained", sb.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Two-requester arbiter that shares the core's single AXI-lite master port between the instruction-fetch bus and the load/store data bus. It sits between the RISC-V core's fetch and LSU units and the AXI-lite master's `valid_i`/`ready_o` request interface. It latches one request at a time, drives it downstream until completion, and routes the response back to the winner. It also inserts the mandatory one-cycle idle gap the master needs between back-to-back transfers.

## Interface
- `ADDR_WIDTH`, default 32: address width, equal to `RISCV_ADDR_WIDTH`.
- `DATA_WIDTH`, default 32: data width, equal to `RISCV_WORD_WIDTH`.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `ibus_valid_i`  in  1  fetch request; read-only.
- `ibus_ready_o`  out  1  fetch completion strobe, one cycle.
- `ibus_addr_i`  in  ADDR_WIDTH  fetch address.
- `ibus_rdata_o`  out  DATA_WIDTH  fetch data; valid only while `ibus_ready_o` is high.
- `dbus_valid_i`  in  1  load/store request.
- `dbus_ready_o`  out  1  load/store completion strobe.
- `dbus_addr_i`  in  ADDR_WIDTH  data address.
- `dbus_wdata_i`  in  DATA_WIDTH  store data.
- `dbus_we_i`  in  4  byte write enables; 0 means load.
- `dbus_rdata_o`  out  DATA_WIDTH  load data; valid only while `dbus_ready_o` is high.
- `m_valid_o`  out  1  request to the AXI-lite master.
- `m_ready_i`  in  1  master completion, i.e. bvalid or rvalid.
- `m_addr_o`  out  ADDR_WIDTH  latched address.
- `m_wdata_o`  out  DATA_WIDTH  latched store data.
- `m_we_o`  out  4  latched byte enables; forced to 0 for ibus.
- `m_rdata_i`  in  DATA_WIDTH  master read data.

## Operation
- **States.**
  - `IDLE`: `m_valid_o` = 0; arbitrates.
  - `BUSY`: `m_valid_o` = 1; waits for `m_ready_i`.
- **Arbitration in IDLE.** Only one requester valid: grant it. Both valid: grant the port flagged by the round-robin bit `prio`.
  - At grant, latch `addr`, `wdata`, `we` and the owner (`gnt`) into registers. Move to BUSY.
  - Set `prio` to the non-granted port.
  - Reset value of `prio` is dbus.
  - For an ibus grant, latch `m_we_o` = 0 and `m_wdata_o` = 0.
- **BUSY.** Downstream outputs come only from the latched registers. Requester inputs are ignored until the state returns to IDLE.
- **Completion.** When `m_ready_i` = 1 in BUSY:
  - Combinationally assert `<gnt>_ready_o` = 1 and drive `<gnt>_rdata_o` = `m_rdata_i`.
  - Next state is IDLE.
  - Exception: if the owner dropped `valid` during BUSY (tracked by the sticky `abandon` flag), the ready strobe is suppressed and the response is discarded.
- **Idle gap.** IDLE always lasts at least one cycle after a completion. `m_valid_o` is low for at least one cycle between transfers; the master clears its handshake-ack flags during this cycle.
- **Outputs outside completion.** `*_ready_o` = 0 outside BUSY and whenever `m_ready_i` = 0. `*_rdata_o` = 0 whenever the corresponding ready is 0.
- **Spurious ready.** `m_ready_i` in IDLE is ignored: no ready strobe, no state change.
- **Reset.** On `rst`, all outputs are 0: `m_valid_o`, `m_addr_o`, `m_wdata_o`, `m_we_o`, both `ready_o`, both `rdata_o`. State goes to IDLE, `prio` = dbus, `abandon` = 0.
  - Reset mid-BUSY drops the transaction; the master is reset in the same domain.

## Timing
- **Grant latency.** Request seen in IDLE at cycle N gives `m_valid_o` = 1 at N+1. Minimum requester latency is 2 cycles plus the master's latency.
- **Completion cycle.** With `m_ready_i` high at cycle T:
  - `ready_o` is high at T.
  - `m_valid_o` is low at T+1.
  - The earliest next `m_valid_o` is T+2.
- **Throughput.** Back-to-back maximum is one transfer per (master latency + 2) cycles.
- **No combinational paths** from requester inputs to `m_*` outputs. The only combinational paths are `m_ready_i`/`m_rdata_i` to the requester outputs.
- **Simultaneous events.** A new request arriving in the completion cycle T is not granted until IDLE at T+1.

## Test plan
- **Single fetch.** ibus read at `0x100` only; master returns `0xDEADBEEF` after 3 cycles.
  - Required: `m_valid_o` high from N+1; `m_we_o` = 0; `ibus_ready_o` pulses once with `ibus_rdata_o` = `0xDEADBEEF`; `dbus_ready_o` stays 0.
- **Store.** dbus store `addr` = `0x2000`, `wdata` = `0x12345678`, `we` = `0xF`.
  - Required: `m_addr_o`/`m_wdata_o`/`m_we_o` match and stay stable through BUSY; one `dbus_ready_o` pulse.
- **Contention.** Both ports request continuously after reset.
  - Required: grant order is dbus, ibus, dbus, ibus; `m_valid_o` is low for exactly one cycle between transfers.
- **Abandon.** dbus load granted, then `dbus_valid_i` dropped one cycle later.
  - Required: the transfer still completes downstream; `dbus_ready_o` is never asserted; the next request is served normally.
- **Reset mid-transfer.** Assert `rst` during BUSY.
  - Required: next cycle all outputs are 0 and the state is IDLE. A pending request after reset release with both ports valid is granted to dbus.
- **Spurious ready.** Pulse `m_ready_i` while IDLE with no requests.
  - Required: no ready strobes, `m_valid_o` stays 0.
